// File: rtl/proc_seq_ctrl.sv
// Programmable microsequencer for the two-register accumulator datapath: a host-loadable
// 16-entry control store stepped one microinstruction per cycle after a start handshake.
module proc_seq_ctrl #(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned IMM_W  = 4,
    localparam int unsigned INSN_W = 6 + PC_W + IMM_W,
    localparam int unsigned DEPTH  = 1 << PC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_wen,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [INSN_W-1:0] prog_data,
    input  logic              start_val,
    output logic              start_rdy,
    input  logic [PC_W-1:0]   start_count,
    output logic              busy,
    output logic              done,
    output logic              regA_en,
    output logic              regA_sel,
    output logic              regB_en,
    output logic              regB_sel,
    output logic [IMM_W-1:0]  imm,
    output logic [PC_W-1:0]   pc
);

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    typedef enum logic [1:0] {
        OpNext = 2'b00,
        OpHalt = 2'b01,
        OpLoop = 2'b10,
        OpJump = 2'b11
    } op_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   loop_cnt_q, loop_cnt_d;
    logic              done_q, done_d;
    logic              store_we;
    logic [INSN_W-1:0] store_q [DEPTH];

    logic [INSN_W-1:0] cs;
    op_e               cs_op;
    logic [PC_W-1:0]   cs_target;
    logic [PC_W-1:0]   pc_inc;

    assign cs        = store_q[pc_q];
    assign cs_op     = op_e'(cs[INSN_W-1 -: 2]);
    assign cs_target = cs[INSN_W-3 -: PC_W];
    assign pc_inc    = pc_q + PC_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        loop_cnt_d = loop_cnt_q;
        done_d     = 1'b0;
        store_we   = 1'b0;
        start_rdy  = 1'b0;
        busy       = 1'b0;
        regA_en    = 1'b0;
        regA_sel   = 1'b0;
        regB_en    = 1'b0;
        regB_sel   = 1'b0;
        imm        = '0;

        unique case (state_q)
            StIdle: begin
                start_rdy = 1'b1;
                store_we  = prog_wen;
                if (start_val) begin
                    state_d    = StRun;
                    pc_d       = '0;
                    loop_cnt_d = start_count;
                end
            end
            StRun: begin
                busy     = 1'b1;
                regA_en  = cs[IMM_W+3];
                regA_sel = cs[IMM_W+2];
                regB_en  = cs[IMM_W+1];
                regB_sel = cs[IMM_W];
                imm      = cs[IMM_W-1:0];
                unique case (cs_op)
                    OpNext: pc_d = pc_inc;
                    OpJump: pc_d = cs_target;
                    OpLoop: begin
                        // An exhausted counter falls through instead of underflowing.
                        if (loop_cnt_q != '0) begin
                            loop_cnt_d = loop_cnt_q - PC_W'(1);
                            pc_d       = cs_target;
                        end else begin
                            pc_d = pc_inc;
                        end
                    end
                    OpHalt: begin
                        state_d = StIdle;
                        pc_d    = '0;
                        done_d  = 1'b1;
                    end
                    default: pc_d = pc_inc;
                endcase
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            loop_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            loop_cnt_q <= loop_cnt_d;
            done_q     <= done_d;
        end
    end

    // Writes land at the edge, so a write in the start cycle is seen by the first fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_q <= '{default: '0};
        end else if (store_we) begin
            store_q[prog_addr] <= prog_data;
        end
    end

    assign done = done_q;
    assign pc   = pc_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Randomized and directed bench for proc_seq_ctrl against a program-interpreting model.
module tb_proc_seq_ctrl;

    localparam int PC_W   = 4;
    localparam int IMM_W  = 4;
    localparam int INSN_W = 6 + PC_W + IMM_W;
    localparam int DEPTH  = 1 << PC_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              prog_wen;
    logic [PC_W-1:0]   prog_addr;
    logic [INSN_W-1:0] prog_data;
    logic              start_val;
    logic              start_rdy;
    logic [PC_W-1:0]   start_count;
    logic              busy;
    logic              done;
    logic              regA_en, regA_sel, regB_en, regB_sel;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   pc;
    logic [7:0]        ctl;

    int n_tests = 0;
    int n_fail  = 0;
    logic [INSN_W-1:0] m_store [DEPTH];

    assign ctl = {regA_en, regA_sel, regB_en, regB_sel, imm};

    proc_seq_ctrl #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_wen   (prog_wen),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start_val  (start_val),
        .start_rdy  (start_rdy),
        .start_count(start_count),
        .busy       (busy),
        .done       (done),
        .regA_en    (regA_en),
        .regA_sel   (regA_sel),
        .regB_en    (regB_en),
        .regB_sel   (regB_sel),
        .imm        (imm),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " pc"}, pc, 0);
        check({tag, " ctl"}, ctl, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " start_rdy"}, start_rdy, 1);
    endtask

    // Called one time unit after a rising edge; reset pulse stays clear of the next edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        foreach (m_store[i]) m_store[i] = '0;
        check_idle("reset");
        check("reset done", done, 0);
        tick();
    endtask

    task automatic write_entry(input int addr, input logic [INSN_W-1:0] data);
        prog_wen  = 1'b1;
        prog_addr = PC_W'(addr);
        prog_data = data;
        tick();
        prog_wen = 1'b0;
        m_store[addr] = data;
    endtask

    // Interpret the program from address 0, then compare the DUT cycle by cycle.
    task automatic run_prog(input int cnt, input int max_steps, input bit same_wr,
                            input int wa, input logic [INSN_W-1:0] wd, input bit wen_in_run);
        int         exp_pc[$];
        logic [7:0] exp_ctl[$];
        bit         halted;
        int         p;
        int         c;
        halted = 1'b0;
        if (same_wr) m_store[wa] = wd;
        p = 0;
        c = cnt;
        for (int s = 0; s < max_steps && !halted; s++) begin
            exp_pc.push_back(p);
            exp_ctl.push_back(m_store[p][7:0]);
            case (m_store[p][13:12])
                2'b00: p = (p + 1) % DEPTH;
                2'b01: halted = 1'b1;
                2'b10: begin
                    if (c > 0) begin
                        c--;
                        p = int'(m_store[p][11:8]);
                    end else begin
                        p = (p + 1) % DEPTH;
                    end
                end
                default: p = int'(m_store[p][11:8]);
            endcase
        end

        check("start_rdy before start", start_rdy, 1);
        start_val   = 1'b1;
        start_count = PC_W'(cnt);
        if (same_wr) begin
            prog_wen  = 1'b1;
            prog_addr = PC_W'(wa);
            prog_data = wd;
        end
        tick();
        start_val = 1'b0;
        prog_wen  = 1'b0;
        for (int s = 0; s < exp_pc.size(); s++) begin
            if (wen_in_run) begin
                prog_wen  = 1'b1;
                prog_addr = PC_W'(1);
                prog_data = 14'h1000;
            end
            check($sformatf("run step %0d pc", s), pc, exp_pc[s]);
            check($sformatf("run step %0d ctl", s), ctl, exp_ctl[s]);
            check($sformatf("run step %0d busy", s), busy, 1);
            check($sformatf("run step %0d done", s), done, 0);
            tick();
        end
        prog_wen = 1'b0;
        if (halted) begin
            check("done after halt", done, 1);
            check_idle("done cycle");
            tick();
            check("done one cycle", done, 0);
        end else begin
            do_reset();
        end
    endtask

    initial begin
        reset       = 1'b1;
        prog_wen    = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        start_val   = 1'b0;
        start_count = '0;
        #12;
        reset = 1'b0;
        foreach (m_store[i]) m_store[i] = '0;
        tick();
        check_idle("power-on");
        check("power-on done", done, 0);

        // Reset mid-RUN clears outputs before the next edge and wipes the store.
        for (int a = 0; a < DEPTH; a++) write_entry(a, 14'h00A5);
        start_val = 1'b1;
        tick();
        start_val = 1'b0;
        tick();
        tick();
        check("pre-reset pc", pc, 2);
        check("pre-reset ctl", ctl, 8'hA5);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async reset");
        #1;
        reset = 1'b0;
        foreach (m_store[i]) m_store[i] = '0;
        @(posedge clk);
        #1;
        run_prog(0, 17, 1'b0, 0, '0, 1'b0);

        // Straight-line program.
        write_entry(0, 14'h0080);
        write_entry(1, 14'h0021);
        write_entry(2, 14'h00C0);
        write_entry(3, 14'h0030);
        write_entry(4, 14'h10C0);
        run_prog(0, 20, 1'b0, 0, '0, 1'b0);

        // Counted loop.
        do_reset();
        write_entry(0, 14'h0021);
        write_entry(1, 14'h0030);
        write_entry(2, 14'h2180);
        write_entry(3, 14'h1000);
        run_prog(2, 20, 1'b0, 0, '0, 1'b0);

        // Jump and wrap, then patch address 0 to fall through.
        do_reset();
        write_entry(0, 14'h3F00);
        write_entry(15, 14'h0000);
        write_entry(1, 14'h1000);
        run_prog(0, 12, 1'b0, 0, '0, 1'b0);
        write_entry(1, 14'h1000);
        write_entry(0, 14'h0000);
        run_prog(0, 12, 1'b0, 0, '0, 1'b0);

        // Writes during RUN are ignored.
        do_reset();
        write_entry(0, 14'h0040);
        write_entry(1, 14'h0010);
        write_entry(2, 14'h1003);
        run_prog(0, 12, 1'b0, 0, '0, 1'b1);
        run_prog(0, 12, 1'b0, 0, '0, 1'b0);

        // start_val held high: restart accepted in each done cycle.
        do_reset();
        write_entry(0, 14'h0081);
        write_entry(1, 14'h1042);
        start_val = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) begin
            check("b2b pc0", pc, 0);
            check("b2b ctl0", ctl, 8'h81);
            check("b2b done0", done, 0);
            tick();
            check("b2b pc1", pc, 1);
            check("b2b ctl1", ctl, 8'h42);
            check("b2b done1", done, 0);
            tick();
            check("b2b done", done, 1);
            check("b2b start_rdy", start_rdy, 1);
            check("b2b busy", busy, 0);
            tick();
        end
        start_val = 1'b0;
        check("b2b restarted busy", busy, 1);
        do_reset();

        // Same-cycle write and start.
        run_prog(0, 5, 1'b1, 0, 14'h1005, 1'b0);

        // Randomized programs.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            for (int w = 0, n = $urandom_range(1, 8); w < n; w++)
                write_entry($urandom_range(0, DEPTH - 1), INSN_W'($urandom));
            run_prog($urandom_range(0, DEPTH - 1), 40, $urandom_range(0, 3) == 0,
                     $urandom_range(0, DEPTH - 1), INSN_W'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
